// File: rtl/multi_timer.sv
// multi_timer: N_CH independent countdown timers that share one tick strobe.
// Each channel has an IDLE / RUN / DONE state machine and a WIDTH-bit counter.
// A channel runs in one-shot mode or auto-reload mode.
//
// Optional feature: define MULTI_TIMER_PRESCALE_EN to divide timer_tick by PRESCALE.
// This uses one free-running divider shared by all channels.
//
// Ports:
//   clk           sole clock, rising edge
//   reset         synchronous, active-high reset
//   timer_tick    shared count-enable strobe
//   timer_start   per-channel start/restart strobe   [N_CH]
//   timer_pause   per-channel pause level            [N_CH]
//   timer_reload  per-channel mode, 1 = auto-reload  [N_CH]
//   load_val      per-channel start value            [N_CH*WIDTH]
//   count         per-channel current count          [N_CH*WIDTH]
//   timer_up      high while the channel is in DONE  [N_CH]
//   timer_expire  one-cycle pulse per expiry         [N_CH]
module multi_timer #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned WIDTH    = 7,
    parameter int unsigned PRESCALE = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    timer_tick,
    input  logic [N_CH-1:0]         timer_start,
    input  logic [N_CH-1:0]         timer_pause,
    input  logic [N_CH-1:0]         timer_reload,
    input  logic [N_CH*WIDTH-1:0]   load_val,
    output logic [N_CH*WIDTH-1:0]   count,
    output logic [N_CH-1:0]         timer_up,
    output logic [N_CH-1:0]         timer_expire
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    logic eff_tick;

`ifdef MULTI_TIMER_PRESCALE_EN
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;

    // Shared free-running divider: it advances on every timer_tick and wraps at PRESCALE-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else if (timer_tick) begin
            pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        end
    end

    // When PRESCALE == 1, pre_q stays at 0, which equals PRE_LAST. The tick then passes straight through.
    assign eff_tick = timer_tick & (pre_q == PRE_LAST);
`else
    // No divider in this build. The PRESCALE term is always true for every legal value.
    assign eff_tick = timer_tick & (PRESCALE != 0);
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [WIDTH-1:0] ld;
        state_t           state_q, state_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic             exp_q, exp_d;
        logic             up_q;

        assign ld = load_val[i*WIDTH +: WIDTH];

        // State register. The expire pulse and the up flag are registered here as well.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                exp_q   <= 1'b0;
                up_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                exp_q   <= exp_d;
                up_q    <= (state_d == DONE);
            end
        end

        // Next-state logic. Start has priority over tick, pause and expiry.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            exp_d   = 1'b0;
            if (timer_start[i]) begin
                cnt_d = ld;
                if (ld == '0) begin
                    state_d = DONE;
                    exp_d   = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end else if (state_q == RUN && eff_tick && !timer_pause[i]) begin
                if (cnt_q > WIDTH'(1)) begin
                    cnt_d = cnt_q - WIDTH'(1);
                end else begin
                    exp_d = 1'b1;
                    // A reload value of zero cannot restart the run. The channel ends instead,
                    // so that count never shows 0 while in RUN.
                    if (timer_reload[i] && ld != '0) begin
                        cnt_d = ld;
                    end else begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
            end
        end

        assign count[i*WIDTH +: WIDTH] = cnt_q;
        assign timer_up[i]             = up_q;
        assign timer_expire[i]         = exp_q;
    end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter N_CH, default 2: number of independent countdown channels, range 1..16.
REQ-002 Parameter WIDTH, default 7: counter width per channel, range 2..32.
REQ-003 Parameter PRESCALE, default 4: tick divider used only under MULTI_TIMER_PRESCALE_EN, range 1..2^16.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 timer_tick  input  1  shared count-enable strobe, one cycle wide.
REQ-007 timer_start  input  N_CH  per-channel start/restart strobe.
REQ-008 timer_pause  input  N_CH  per-channel level; while high, ticks are ignored.
REQ-009 timer_reload  input  N_CH  per-channel mode: 0 one-shot, 1 auto-reload; sampled at start and at each expiry.
REQ-010 load_val  input  N_CH*WIDTH  start value; channel i is bits [i*WIDTH +: WIDTH].
REQ-011 count  output  N_CH*WIDTH  current count per channel, same packing as load_val.
REQ-012 timer_up  output  N_CH  level; high while channel is in DONE.
REQ-013 timer_expire  output  N_CH  one-cycle registered pulse on each expiry event.

Function
REQ-014 Each channel has a state machine with states IDLE, RUN, DONE and a WIDTH-bit counter.
REQ-015 timer_start[i] in any state: load count <= load_val[i] and enter RUN next cycle; start overrides tick, pause and expiry in the same cycle.
REQ-016 Start with load_val[i]==0: enter DONE, count 0, timer_expire[i] pulses next cycle, regardless of reload mode.
REQ-017 RUN, effective tick high, pause low, count>1: count decrements by 1.
REQ-018 RUN, effective tick, count==1, reload low: count <= 0, enter DONE, timer_expire[i] high for exactly that next cycle.
REQ-019 RUN, effective tick, count==1, reload high: count <= load_val[i] (re-sampled), stay RUN, timer_expire[i] pulses; count never shows 0 in this mode.
REQ-020 Pause high in RUN: count and state hold; no missed-tick accumulation on release.
REQ-021 IDLE and DONE: count holds; ticks have no effect; only start leaves these states.
REQ-022 timer_up[i] and timer_expire[i] derive from registered state only; no combinational path from inputs.
REQ-023 Channels are fully independent; simultaneous events on different channels all take effect in the same cycle.
REQ-024 No underflow: count never wraps below 0 or above load value.

Reset
REQ-025 reset high: all channels IDLE, count 0, timer_up 0, timer_expire 0, prescaler counter 0.
REQ-026 reset overrides start, tick and all other inputs in the same cycle; reset mid-count discards the run and suppresses any pending expire pulse.
REQ-027 After reset release, channels stay IDLE until their timer_start strobe.

Configuration
REQ-028 Macro MULTI_TIMER_PRESCALE_EN defined: effective tick = one pulse per PRESCALE timer_tick strobes, from a shared free-running divider counting timer_tick, wrapping at PRESCALE-1; PRESCALE==1 equals passthrough.
REQ-029 Macro undefined: effective tick = timer_tick directly; no divider logic; PRESCALE ignored.

Verification
REQ-030 Reset, then start ch0 load 5 one-shot, tick every cycle -> count 5,4,3,2,1,0; timer_expire[0] single pulse; timer_up[0] stays high; ch1 count stays 0.
REQ-031 Ch1 reload=1 load 3, tick every cycle for 9 cycles -> count 3,2,1,3,2,1,3,2,1 with expire pulse each wrap; timer_up[1] never high.
REQ-032 Ch0 load 4, pause high for 3 ticks mid-run, start asserted in same cycle as tick at count 1 -> count holds during pause; start wins, count 4, no expire pulse.
REQ-033 Start with load_val 0 -> DONE and expire pulse next cycle; reset asserted at count 2 of a 6-count run -> count 0, IDLE, no expire pulse.
REQ-034 MULTI_TIMER_PRESCALE_EN, PRESCALE=4, load 2, tick every cycle -> count decrements once per 4 ticks; expire after 8 ticks; undefined build expires after 2 ticks.
